// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch buffer: defaults and the
// fetch-entry record stored per slot.
package if_fetch_buffer_pkg;

   localparam int unsigned FB_DEPTH    = 4;
   localparam logic [31:0] FB_RESET_PC = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the fetch buffer.
interface if_fetch_buffer_if;

   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [31:0] out_instr;
   logic        out_ready;
   logic [2:0]  count;
   logic [31:0] last_pc;
   logic        misalign;

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_pc4, out_instr, count, last_pc, misalign
   );

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, out_pc4, out_instr, count, last_pc, misalign
   );

endinterface

// File: rtl/if_fetch_buffer_mem.sv
// Fetch-entry storage: synchronous write, asynchronous read, contents not reset.
module fetch_buf_mem
   import if_fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = FB_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fetch_entry_t  wdata,
   input  logic [AW-1:0] raddr,
   output fetch_entry_t  rdata
);

   fetch_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_buffer.sv
// Circular fetch buffer between fetch and decode; in_ready drives PCWr.
// Flush empties the queue but leaves last_pc and the misalign flag alone.
module if_fetch_buffer
   import if_fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH    = FB_DEPTH,
   parameter logic [31:0] RESET_PC = FB_RESET_PC
) (
   input logic               clk,
   input logic               rst,
   if_fetch_buffer_if.slave  bus
);

   localparam int unsigned   AW      = $clog2(DEPTH);
   localparam logic [2:0]    DEPTH_C = 3'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [2:0]    cnt;
   logic [31:0]   last_pc_q;
   logic          mis_q;
   logic          in_rdy;
   logic          out_vld;
   logic          push;
   logic          pop;
   fetch_entry_t  wentry;
   fetch_entry_t  head;

   // Full blocks push even when a pop is taken in the same cycle.
   assign in_rdy  = (cnt < DEPTH_C) && !bus.flush;
   assign out_vld = (cnt != 3'd0) && !bus.flush;
   assign push    = bus.in_valid && in_rdy;
   assign pop     = out_vld && bus.out_ready;

   assign wentry.pc    = bus.in_pc;
   assign wentry.instr = bus.in_instr;

   fetch_buf_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wentry),
      .raddr (rd_ptr),
      .rdata (head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         last_pc_q <= RESET_PC;
         mis_q     <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + PTR_ONE;
            last_pc_q <= bus.in_pc;
            if (bus.in_pc[1:0] != 2'b00) mis_q <= 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         cnt <= cnt + {2'b00, push} - {2'b00, pop};
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_pc    = head.pc;
   assign bus.out_pc4   = head.pc + 32'd4;
   assign bus.out_instr = head.instr;
   assign bus.count     = cnt;
   assign bus.last_pc   = last_pc_q;
   assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Scoreboard bench for if_fetch_buffer: expected entries queued on modelled
// pushes and compared against the head when the model predicts a pop.
module tb_if_fetch_buffer;
   import if_fetch_buffer_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   int           m_cnt = 0;
   logic [31:0]  m_last_pc = 32'h0000_3000;
   logic         m_mis = 1'b0;
   fetch_entry_t exp_q[$];

   if_fetch_buffer_if bus ();

   if_fetch_buffer #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_3000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Update the model from the inputs currently driven, then cross one edge.
   task automatic advance();
      bit pu, po;
      fetch_entry_t e;
      pu = bus.in_valid && (m_cnt < DEPTH) && !bus.flush;
      po = (m_cnt != 0) && !bus.flush && bus.out_ready;
      if (bus.flush) begin
         exp_q.delete();
         m_cnt = 0;
      end else begin
         if (po) void'(exp_q.pop_front());
         if (pu) begin
            e.pc = bus.in_pc;
            e.instr = bus.in_instr;
            exp_q.push_back(e);
            m_last_pc = bus.in_pc;
            if (bus.in_pc[1:0] != 2'b00) m_mis = 1'b1;
         end
         m_cnt = m_cnt + int'(pu) - int'(po);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #4;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.last_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_last_pc got %h want 00003000", bus.last_pc); end
      checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", bus.misalign); end
      @(posedge clk); #1;
      rst = 1'b0;
      m_cnt = 0; m_last_pc = 32'h0000_3000; m_mis = 1'b0; exp_q.delete();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_pc = 32'h0000_3000 + 32'(4 * i);
         bus.in_instr = $urandom;
         bus.out_ready = 1'b0;
         #3;
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %b want 1", i, bus.in_ready); end
         if (i == 0) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_empty got %b want 0", bus.out_valid); end
         end
         if (i == 1) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_one got %b want 1", bus.out_valid); end
         end
         advance();
      end
      bus.in_valid = 1'b0;
      #3;
      checks++; if (bus.count !== 3'(m_cnt) || m_cnt != 4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full got %b want 0", bus.in_ready); end
      checks++; if (bus.out_pc !== 32'h0000_3000) begin errors++; $display("FAIL fill_out_pc got %h want 00003000", bus.out_pc); end
      checks++; if (bus.out_pc4 !== 32'h0000_3004) begin errors++; $display("FAIL fill_out_pc4 got %h want 00003004", bus.out_pc4); end
      checks++; if (bus.out_instr !== exp_q[0].instr) begin errors++; $display("FAIL fill_out_instr got %h want %h", bus.out_instr, exp_q[0].instr); end
      checks++; if (bus.last_pc !== 32'h0000_300C) begin errors++; $display("FAIL fill_last_pc got %h want 0000300c", bus.last_pc); end
      advance();
   endtask

   task automatic test_full_pop();
      bus.in_valid = 1'b1; bus.in_pc = 32'h0000_3010; bus.in_instr = $urandom;
      bus.out_ready = 1'b1;
      #3;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_in_ready got %b want 0", bus.in_ready); end
      checks++; if (bus.out_pc !== exp_q[0].pc || bus.out_instr !== exp_q[0].instr)
         begin errors++; $display("FAIL fullpop_head got %h/%h want %h/%h", bus.out_pc, bus.out_instr, exp_q[0].pc, exp_q[0].instr); end
      advance();
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      #3;
      checks++; if (bus.count !== 3'(m_cnt) || m_cnt != 3) begin errors++; $display("FAIL fullpop_count got %0d want 3", bus.count); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_in_ready_after got %b want 1", bus.in_ready); end
      checks++; if (bus.last_pc !== 32'h0000_300C) begin errors++; $display("FAIL fullpop_last_pc got %h want 0000300c", bus.last_pc); end
      advance();
   endtask

   task automatic test_back_to_back();
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #3;
      checks++; if (bus.out_pc !== exp_q[0].pc) begin errors++; $display("FAIL b2b_drain_head got %h want %h", bus.out_pc, exp_q[0].pc); end
      advance();
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_pc = 32'h0000_3100 + 32'(4 * i);
         bus.in_instr = $urandom;
         bus.out_ready = 1'b1;
         #3;
         checks++; if (bus.out_pc !== exp_q[0].pc || bus.out_instr !== exp_q[0].instr)
            begin errors++; $display("FAIL b2b_head[%0d] got %h/%h want %h/%h", i, bus.out_pc, bus.out_instr, exp_q[0].pc, exp_q[0].instr); end
         checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 2", i, bus.count); end
         advance();
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      #3;
      checks++; if (bus.count !== 3'(m_cnt)) begin errors++; $display("FAIL b2b_count_end got %0d want %0d", bus.count, m_cnt); end
      checks++; if (bus.out_pc !== 32'h0000_3110) begin errors++; $display("FAIL b2b_head_end got %h want 00003110", bus.out_pc); end
      advance();
   endtask

   task automatic test_flush();
      bus.in_valid = 1'b1; bus.in_pc = 32'h0000_3200; bus.in_instr = $urandom;
      bus.out_ready = 1'b0;
      advance();
      bus.in_pc = 32'h0000_3204;
      bus.out_ready = 1'b1;
      bus.flush = 1'b1;
      #3;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
      advance();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      #3;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid_after got %b want 0", bus.out_valid); end
      checks++; if (bus.last_pc !== 32'h0000_3200) begin errors++; $display("FAIL flush_last_pc got %h want 00003200", bus.last_pc); end
      bus.in_valid = 1'b1; bus.in_pc = 32'h0000_3300; bus.in_instr = $urandom;
      advance();
      bus.in_valid = 1'b0;
      #3;
      checks++; if (bus.out_pc !== exp_q[0].pc || bus.out_instr !== exp_q[0].instr)
         begin errors++; $display("FAIL flush_new_head got %h/%h want %h/%h", bus.out_pc, bus.out_instr, exp_q[0].pc, exp_q[0].instr); end
      bus.out_ready = 1'b1;
      advance();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_misalign();
      checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL mis_before got %b want 0", bus.misalign); end
      bus.in_valid = 1'b1; bus.in_pc = 32'h0000_3002; bus.in_instr = $urandom;
      advance();
      bus.in_valid = 1'b0;
      #3;
      checks++; if (bus.misalign !== m_mis || !m_mis) begin errors++; $display("FAIL mis_set got %b want 1", bus.misalign); end
      checks++; if (bus.out_pc !== 32'h0000_3002) begin errors++; $display("FAIL mis_stored got %h want 00003002", bus.out_pc); end
      bus.flush = 1'b1;
      advance();
      bus.flush = 1'b0;
      #3;
      checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL mis_after_flush got %b want 1", bus.misalign); end
      bus.in_valid = 1'b1; bus.in_pc = 32'hFFFF_FFFC; bus.in_instr = $urandom;
      advance();
      bus.in_valid = 1'b0;
      #3;
      checks++; if (bus.out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out_pc got %h want fffffffc", bus.out_pc); end
      checks++; if (bus.out_pc4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_out_pc4 got %h want 00000000", bus.out_pc4); end
      checks++; if (bus.last_pc !== m_last_pc) begin errors++; $display("FAIL wrap_last_pc got %h want %h", bus.last_pc, m_last_pc); end
      advance();
   endtask

   task automatic test_async_reset();
      bus.in_valid = 1'b1; bus.in_pc = 32'h0000_3400; bus.in_instr = $urandom;
      advance();
      bus.in_valid = 1'b0;
      #2;
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL arst_pre_count got %0d want 2", bus.count); end
      rst = 1'b1;
      #1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", bus.count); end
      checks++; if (bus.last_pc !== 32'h0000_3000) begin errors++; $display("FAIL arst_last_pc got %h want 00003000", bus.last_pc); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL arst_misalign got %b want 0", bus.misalign); end
      #1;
      rst = 1'b0;
      m_cnt = 0; m_last_pc = 32'h0000_3000; m_mis = 1'b0; exp_q.delete();
      bus.in_valid = 1'b1; bus.in_pc = 32'h0000_3000; bus.in_instr = $urandom;
      advance();
      bus.in_valid = 1'b0;
      #3;
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL arst_first_push got %0d want 1", bus.count); end
      checks++; if (bus.out_pc !== exp_q[0].pc || bus.out_instr !== exp_q[0].instr)
         begin errors++; $display("FAIL arst_first_head got %h/%h want %h/%h", bus.out_pc, bus.out_instr, exp_q[0].pc, exp_q[0].instr); end
      advance();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_pop();
      test_back_to_back();
      test_flush();
      test_misalign();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
